add_sub_pipe: RTL
=================

// Module: add_sub_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined adder/subtractor with accumulator, flags and
//  optional saturation; successor to the fixed 8-bit combinational add/sub.
//  Carry chain split at WIDTH/2: low half in stage 1, high half in stage 2.
//  Valid/ready on both sides; sits between operand sources and datapath sinks.
// PARAMETERS
//  WIDTH  16  operand/result width; even, >= 4; LO = WIDTH/2
//  SAT    0   1 = clamp result on overflow, 0 = wrap
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat (transfer = in_valid & in_ready)
//  in_op      in   3      0 ADD a+b, 1 SUB a-b, 2 ACC_ADD acc+b, 3 ACC_SUB acc-b,
//                         4 LOAD (result=b, acc<=b), 5-7 NOP (result 0, acc kept)
//  in_signed  in   1      1 = two's-complement flag/saturation rules
//  in_a       in   WIDTH  operand a (ignored by ops 2-7)
//  in_b       in   WIDTH  operand b
//  acc_clr    in   1      synchronous accumulator clear
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts (transfer = out_valid & out_ready)
//  out_sum    out  WIDTH  result
//  out_carry  out  1      unsigned carry-out (SUB: 1 = no borrow, i.e. a>=b)
//  out_ovf    out  1      signed: signed overflow; unsigned: ADD carry / SUB borrow
//  out_zero   out  1      out_sum == 0 (after saturation)
//  out_neg    out  1      out_sum[WIDTH-1]
//  acc        out  WIDTH  accumulator value
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): s1/s2 valid=0, out_valid=0,
//    out_sum/flags=0, acc=0; in_ready=1 once out of reset.
//  - Subtract = x + ~b + 1 (carry-in 1 to low slice). Stage 1 registers low
//    LO bits, low carry, high operand halves, op, signed. Stage 2 adds high
//    halves + registered carry, forms flags, applies SAT, registers outputs.
//  - Latency 2 cycles from input transfer to out_valid when not stalled;
//    throughput 1/cycle for non-ACC ops.
//  - Stall: s2 holds while out_valid & !out_ready; s1 advances only if s2
//    empties or advances; in_ready = s1_can_advance & !acc_hazard.
//  - acc_hazard: in_op in {2,3} and an op in {2,3,4} occupies s1 -> in_ready=0
//    (in_ready combinationally depends on in_op). Back-to-back ACC ops: 1/2.
//  - ACC ops read acc at s1 entry. acc updates with the final (saturated)
//    result on the edge the op is loaded into s2; LOAD writes b.
//  - acc_clr: acc<=0 next edge; wins over coincident acc write; in-flight
//    results still delivered unchanged.
//  - SAT=1 on overflow: unsigned ADD -> all ones, unsigned SUB -> 0; signed ->
//    0x7F..F if true result positive else 0x80..0. out_ovf still 1.
//  - NOP: out_sum=0, zero=1, other flags 0. LOAD: flags from b, carry/ovf 0.
//  - rst_n low mid-operation: in-flight beats dropped, no partial output.
//  - Outputs registered; out_* stable while out_valid & !out_ready.
// STRUCTURE
//  - add_sub_pkg: op code localparams (OP_ADD..OP_NOP), op-class helper
//    function is_acc_op.
//  - Sub-module add_sub_slice #(W): W-bit add with cin/cout and b-invert;
//    instantiated twice (low stage 1, high stage 2).
// TESTING (WIDTH=16 unless noted)
//  1 ADD unsigned 0x00FF+0x0001 -> out_sum 0x0100 after 2 cycles, carry=0,
//    ovf=0 (cross-half carry); 0xFFFF+0x0001 -> 0x0000, carry=1, zero=1.
//  2 SUB signed 0x8000-0x0001: SAT=0 -> 0x7FFF ovf=1; SAT=1 -> 0x8000 ovf=1.
//    Unsigned 0x0003-0x0005 SAT=1 -> 0x0000, ovf=1, carry=0.
//  3 LOAD 10 then 3x ACC_ADD b=5 held valid -> results 15,20,25, acc=25,
//    in_ready low 1 cycle before each ACC beat.
//  4 out_ready low 5 cycles, 4 ADD beats offered -> 2 accepted then
//    in_ready=0; on release all 4 delivered in order, none lost/duplicated.
//  5 rst_n low while 2 beats in flight -> out_valid 0 immediately, acc=0,
//    nothing emitted after release.
//  6 acc_clr same cycle ACC_ADD (acc=7,b=1) enters s2 -> out_sum 8, acc=0.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared op codes and op-class helpers for the pipelined adder/subtractor.
package add_sub_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_ACC_ADD = 3'd2,
    OP_ACC_SUB = 3'd3,
    OP_LOAD    = 3'd4,
    OP_NOP     = 3'd5
  } op_e;

  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
  endfunction

  function automatic logic is_sub_op(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_ACC_SUB);
  endfunction

  // Ops that write the accumulator; also the ops an ACC op must not overtake.
  function automatic logic writes_acc(input logic [2:0] op);
    return is_acc_op(op) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/add_sub_slice.sv
// W-bit adder slice with carry-in/out and optional inversion of b.
module add_sub_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         inv_b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff       = inv_b ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/add_sub_pipe.sv
// Two-stage pipelined add/sub with accumulator, flags and optional saturation.
// Carry chain split at WIDTH/2: low slice in stage 1, high slice in stage 2.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned LO = WIDTH / 2;
  localparam int unsigned HI = WIDTH - LO;

  logic          s1_valid_q, s1_valid_d;
  logic [LO-1:0] s1_lo_q, s1_lo_d;
  logic          s1_c_q, s1_c_d;
  logic [HI-1:0] s1_xh_q, s1_xh_d, s1_yh_q, s1_yh_d;
  logic [2:0]    s1_op_q, s1_op_d;
  logic          s1_signed_q, s1_signed_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d, out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d, out_neg_q, out_neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_adv, s1_adv, hazard, in_fire, sub_in, sub2;
  logic [WIDTH-1:0] x, y, raw, res;
  logic [LO-1:0]    lo_sum;
  logic             lo_cout;
  logic [HI-1:0]    hi_sum;
  logic             hi_cout, x_msb, y_msb, ovf;

  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    hazard   = is_acc_op(in_op) && s1_valid_q && writes_acc(s1_op_q);
    in_ready = s1_adv && !hazard;
    in_fire  = in_valid && in_ready;
  end

  // LOAD becomes 0 + b and NOP becomes 0 + 0, so both flow through the adder
  // and naturally produce their required result and flags.
  always_comb begin
    sub_in = is_sub_op(in_op);
    x      = in_a;
    y      = in_b;
    case (in_op)
      OP_ADD, OP_SUB:         x = in_a;
      OP_ACC_ADD, OP_ACC_SUB: x = acc_q;
      OP_LOAD:                x = '0;
      default: begin
        x = '0;
        y = '0;
      end
    endcase
  end

  add_sub_slice #(.W(LO)) u_lo (
    .a     (x[LO-1:0]),
    .b     (y[LO-1:0]),
    .inv_b (sub_in),
    .cin   (sub_in),
    .sum   (lo_sum),
    .cout  (lo_cout)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_c_d      = s1_c_q;
    s1_xh_d     = s1_xh_q;
    s1_yh_d     = s1_yh_q;
    s1_op_d     = s1_op_q;
    s1_signed_d = s1_signed_q;
    if (s1_adv) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_lo_d     = lo_sum;
        s1_c_d      = lo_cout;
        s1_xh_d     = x[WIDTH-1:LO];
        s1_yh_d     = y[WIDTH-1:LO];
        s1_op_d     = in_op;
        s1_signed_d = in_signed;
      end
    end
  end

  assign sub2 = is_sub_op(s1_op_q);

  add_sub_slice #(.W(HI)) u_hi (
    .a     (s1_xh_q),
    .b     (s1_yh_q),
    .inv_b (sub2),
    .cin   (s1_c_q),
    .sum   (hi_sum),
    .cout  (hi_cout)
  );

  // With the same sign on both addends, the true result carries that sign.
  always_comb begin
    raw   = {hi_sum, s1_lo_q};
    x_msb = s1_xh_q[HI-1];
    y_msb = s1_yh_q[HI-1] ^ sub2;
    if (s1_signed_q) ovf = (x_msb == y_msb) && (raw[WIDTH-1] != x_msb);
    else             ovf = sub2 ? !hi_cout : hi_cout;
    res = raw;
    if (SAT && ovf) begin
      if (s1_signed_q) res = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else             res = sub2 ? '0 : '1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;
    out_neg_d   = out_neg_q;
    acc_d       = acc_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sum_d   = res;
        out_carry_d = hi_cout;
        out_ovf_d   = ovf;
        out_zero_d  = (res == '0);
        out_neg_d   = res[WIDTH-1];
        if (writes_acc(s1_op_q)) acc_d = res;
      end
    end
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_xh_q     <= '0;
      s1_yh_q     <= '0;
      s1_op_q     <= '0;
      s1_signed_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_xh_q     <= s1_xh_d;
      s1_yh_q     <= s1_yh_d;
      s1_op_q     <= s1_op_d;
      s1_signed_q <= s1_signed_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
      out_neg_q   <= out_neg_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;
  assign acc       = acc_q;

endmodule
